// File: rtl/dl_rom_sequencer.sv
// HPS ioctl download decoder: splits ROM bytes over four regions, latches DIP bytes,
// and sequences the game-core reset around ROM loads. Optional macro: DL_CHECKSUM_EN.
module dl_rom_sequencer #(
  parameter int          ADDR_W     = 25,
  parameter int unsigned R0_SIZE    = 16384,
  parameter int unsigned R1_SIZE    = 8192,
  parameter int unsigned R2_SIZE    = 8192,
  parameter int unsigned R3_SIZE    = 8192,
  parameter int unsigned POST_HOLD  = 1024,
  parameter logic [7:0]  EXPECT_SUM = 8'h00
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [3:0]        rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              sw_we,
  output logic [2:0]        sw_idx,
  output logic [7:0]        sw_data,
  output logic              core_reset,
  output logic              dl_done,
  output logic              dl_error,
  output logic [ADDR_W-1:0] byte_count,
  output logic [7:0]        dl_sum
);

  localparam int unsigned TOTAL  = R0_SIZE + R1_SIZE + R2_SIZE + R3_SIZE;
  localparam int          HOLD_W = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  function automatic int unsigned region_base(input int k);
    int unsigned b;
    b = 0;
    if (k > 0) b = b + R0_SIZE;
    if (k > 1) b = b + R1_SIZE;
    if (k > 2) b = b + R2_SIZE;
    return b;
  endfunction

  function automatic int unsigned region_size(input int k);
    case (k)
      0:       return R0_SIZE;
      1:       return R1_SIZE;
      2:       return R2_SIZE;
      default: return R3_SIZE;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]                 addr32;
  logic [3:0]                  hit;
  logic [3:0][ADDR_W-1:0]      region_off;
  logic [ADDR_W-1:0]           sel_off;

  assign addr32 = 32'(ioctl_addr);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_region
      localparam int unsigned LO = region_base(gi);
      localparam int unsigned HI = LO + region_size(gi);
      assign hit[gi]        = (addr32 >= LO) && (addr32 < HI);
      assign region_off[gi] = ioctl_addr - ADDR_W'(LO);
    end
  endgenerate

  always_comb begin
    sel_off = '0;
    for (int k = 0; k < 4; k++) begin
      if (hit[k]) sel_off = sel_off | region_off[k];
    end
  end

  logic dl_prev_reg;
  logic rom_wr, rom_ok, in_range, sw_wr;
  logic dl_rise, dl_fall, rom_start;
  logic sum_ok;

  assign in_range  = |hit;
  assign rom_wr    = ioctl_wr & ioctl_download & (ioctl_index == IDX_ROM);
  assign rom_ok    = rom_wr & in_range;
  assign sw_wr     = ioctl_wr & (ioctl_index == IDX_DIP) & (ioctl_addr[ADDR_W-1:3] == '0);
  assign dl_rise   = ioctl_download & ~dl_prev_reg;
  assign dl_fall   = ~ioctl_download & dl_prev_reg;
  assign rom_start = dl_rise & (ioctl_index == IDX_ROM);

  // ---------------------------------------------------------------------------
  // Registered write ports (ROM and DIP)
  // ---------------------------------------------------------------------------
  logic [3:0]        rom_we_reg;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [7:0]        rom_data_reg;
  logic              sw_we_reg;
  logic [2:0]        sw_idx_reg;
  logic [7:0]        sw_data_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_we_reg   <= '0;
      rom_addr_reg <= '0;
      rom_data_reg <= '0;
      sw_we_reg    <= 1'b0;
      sw_idx_reg   <= '0;
      sw_data_reg  <= '0;
    end else begin
      rom_we_reg <= rom_ok ? hit : 4'b0000;
      if (rom_ok) begin
        rom_addr_reg <= sel_off;
        rom_data_reg <= ioctl_dout;
      end
      sw_we_reg <= sw_wr;
      if (sw_wr) begin
        sw_idx_reg  <= ioctl_addr[2:0];
        sw_data_reg <= ioctl_dout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Download / reset sequencer
  // ---------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [ADDR_W-1:0] byte_count_reg, byte_count_next;
  logic              dl_error_reg, dl_error_next;
  logic              dl_done_reg, dl_done_next;
  logic              core_reset_reg, core_reset_next;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      hold_cnt_reg   <= '0;
      byte_count_reg <= '0;
      dl_error_reg   <= 1'b0;
      dl_done_reg    <= 1'b0;
      core_reset_reg <= 1'b1;
      dl_prev_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
      byte_count_reg <= byte_count_next;
      dl_error_reg   <= dl_error_next;
      dl_done_reg    <= dl_done_next;
      core_reset_reg <= core_reset_next;
      dl_prev_reg    <= ioctl_download;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_cnt_next   = hold_cnt_reg;
    byte_count_next = byte_count_reg;
    dl_error_next   = dl_error_reg;
    dl_done_next    = dl_done_reg;

    case (state_reg)
      IDLE: ;
      LOAD: begin
        if (dl_fall) begin
          if ((byte_count_reg == ADDR_W'(TOTAL)) && !dl_error_reg && sum_ok) begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_W'(POST_HOLD - 1);
          end else begin
            dl_error_next = 1'b1;
            state_next    = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_reg == '0) begin
          state_next   = RUN;
          dl_done_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
        end
      end
      RUN: ;
      default: state_next = IDLE;
    endcase

    // A ROM start wins over everything, including an in-progress hold.
    if (rom_start) begin
      state_next      = LOAD;
      byte_count_next = '0;
      dl_error_next   = 1'b0;
      dl_done_next    = 1'b0;
    end

    // Applied after the clear so a byte arriving with the rising edge is counted.
    if (rom_wr) begin
      if (in_range) byte_count_next = byte_count_next + ADDR_W'(1);
      else          dl_error_next   = 1'b1;
    end

    core_reset_next = (state_next != RUN);
  end

  // ---------------------------------------------------------------------------
  // Optional image checksum
  // ---------------------------------------------------------------------------
`ifdef DL_CHECKSUM_EN
  logic [7:0] dl_sum_reg, dl_sum_next;

  always_comb begin
    dl_sum_next = dl_sum_reg;
    if (rom_start) dl_sum_next = '0;
    if (rom_ok)    dl_sum_next = dl_sum_next + ioctl_dout;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) dl_sum_reg <= '0;
    else       dl_sum_reg <= dl_sum_next;
  end

  assign sum_ok = (dl_sum_reg == EXPECT_SUM);
  assign dl_sum = dl_sum_reg;
`else
  logic unused_expect_sum;
  assign unused_expect_sum = ^EXPECT_SUM;
  assign sum_ok = 1'b1;
  assign dl_sum = '0;
`endif

  assign rom_we     = rom_we_reg;
  assign rom_addr   = rom_addr_reg;
  assign rom_data   = rom_data_reg;
  assign sw_we      = sw_we_reg;
  assign sw_idx     = sw_idx_reg;
  assign sw_data    = sw_data_reg;
  assign core_reset = core_reset_reg;
  assign dl_done    = dl_done_reg;
  assign dl_error   = dl_error_reg;
  assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_dl_rom_sequencer.sv
// Directed/randomized bench for dl_rom_sequencer; reference model derives region,
// offset, count, checksum and release timing from the region map by plain arithmetic.
module tb_dl_rom_sequencer;

  localparam int         AW       = 25;
  localparam int         TOTAL    = 128;
  localparam int         HOLD_CYC = 8;
  localparam logic [7:0] TB_SUM   = 8'h40;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic [7:0]    ioctl_index = '0;
  logic [3:0]    rom_we;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          sw_we;
  logic [2:0]    sw_idx;
  logic [7:0]    sw_data;
  logic          core_reset;
  logic          dl_done;
  logic          dl_error;
  logic [AW-1:0] byte_count;
  logic [7:0]    dl_sum;

  dl_rom_sequencer #(
    .ADDR_W(AW), .R0_SIZE(16), .R1_SIZE(16), .R2_SIZE(32), .R3_SIZE(64),
    .POST_HOLD(HOLD_CYC), .EXPECT_SUM(TB_SUM)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_data(rom_data), .sw_we(sw_we), .sw_idx(sw_idx), .sw_data(sw_data),
    .core_reset(core_reset), .dl_done(dl_done), .dl_error(dl_error),
    .byte_count(byte_count), .dl_sum(dl_sum)
  );

`ifdef DL_CHECKSUM_EN
  // Second instance expecting the all-0x01 image sum.
  logic [3:0]    d2_rom_we;
  logic [AW-1:0] d2_rom_addr, d2_byte_count;
  logic [7:0]    d2_rom_data, d2_sw_data, d2_dl_sum;
  logic          d2_sw_we, d2_core_reset, d2_dl_done, d2_dl_error;
  logic [2:0]    d2_sw_idx;

  dl_rom_sequencer #(
    .ADDR_W(AW), .R0_SIZE(16), .R1_SIZE(16), .R2_SIZE(32), .R3_SIZE(64),
    .POST_HOLD(HOLD_CYC), .EXPECT_SUM(8'h80)
  ) dut2 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .rom_we(d2_rom_we), .rom_addr(d2_rom_addr),
    .rom_data(d2_rom_data), .sw_we(d2_sw_we), .sw_idx(d2_sw_idx), .sw_data(d2_sw_data),
    .core_reset(d2_core_reset), .dl_done(d2_dl_done), .dl_error(d2_dl_error),
    .byte_count(d2_byte_count), .dl_sum(d2_dl_sum)
  );
`endif

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  int         q_addr[$];
  logic [7:0] q_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Model: region map 0..15 / 16..31 / 32..63 / 64..127, everything else out of range.
  function automatic int region_of(input int a);
    if (a < 0)        return -1;
    else if (a < 16)  return 0;
    else if (a < 32)  return 1;
    else if (a < 64)  return 2;
    else if (a < 128) return 3;
    else              return -1;
  endfunction

  function automatic int base_of(input int r);
    case (r)
      0:       return 0;
      1:       return 16;
      2:       return 32;
      default: return 64;
    endcase
  endfunction

  // Replays q_addr/q_data as one ROM download, the first byte riding the rising edge.
  task automatic run_download(input string name);
    int         cnt;
    bit         err;
    bit         good;
    bit         held;
    int         r;
    logic [7:0] sum;
    cnt = 0; err = 1'b0; sum = 8'h00;
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    for (int i = 0; i < q_addr.size(); i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = AW'(q_addr[i]);
      ioctl_dout = q_data[i];
      tick();
      r = region_of(q_addr[i]);
      chk("rom_we", 32'(rom_we), (r >= 0) ? 32'(1 << r) : 32'd0);
      if (r >= 0) begin
        chk("rom_addr", 32'(rom_addr), 32'(q_addr[i] - base_of(r)));
        chk("rom_data", 32'(rom_data), 32'(q_data[i]));
        cnt++;
        sum = sum + q_data[i];
      end else begin
        err = 1'b1;
      end
      chk("core_reset_load", 32'(core_reset), 32'd1);
      ioctl_wr = 1'b0;
      tick();
      chk("rom_we_pulse", 32'(rom_we), 32'd0);
    end
    chk("byte_count", 32'(byte_count), 32'(cnt));
    ioctl_download = 1'b0;
    tick();
`ifdef DL_CHECKSUM_EN
    chk("dl_sum", 32'(dl_sum), 32'(sum));
    good = (cnt == TOTAL) && !err && (sum == TB_SUM);
`else
    chk("dl_sum", 32'(dl_sum), 32'd0);
    good = (cnt == TOTAL) && !err;
`endif
    if (good) begin
      chk("core_reset_hold0", 32'(core_reset), 32'd1);
      held = 1'b1;
      repeat (HOLD_CYC - 1) begin
        tick();
        if (core_reset !== 1'b1) held = 1'b0;
      end
      chk("core_reset_held", 32'(held), 32'd1);
      tick();
      chk("core_reset_release", 32'(core_reset), 32'd0);
      chk("dl_done_good", 32'(dl_done), 32'd1);
      chk("dl_error_good", 32'(dl_error), 32'd0);
    end else begin
      chk("dl_error_bad", 32'(dl_error), 32'd1);
      chk("dl_done_bad", 32'(dl_done), 32'd0);
      repeat (HOLD_CYC + 2) tick();
      chk("core_reset_kept", 32'(core_reset), 32'd1);
    end
    $display("[TB] download %s: writes=%0d in_range=%0d sum=0x%02h released=%0d",
             name, q_addr.size(), cnt, sum, good);
  endtask

  task automatic fill_full(input bit shuffle, input bit ones);
    logic [7:0] s;
    logic [7:0] d;
    int         j;
    int         t;
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < TOTAL; i++) q_addr.push_back(i);
    if (shuffle) begin
      for (int i = TOTAL - 1; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        t = q_addr[i]; q_addr[i] = q_addr[j]; q_addr[j] = t;
      end
    end
    s = 8'h00;
    for (int i = 0; i < TOTAL; i++) begin
      d = ones ? 8'h01 : 8'($urandom);
      if (!ones && i == TOTAL - 1) d = TB_SUM - s;
      s = s + d;
      q_data.push_back(d);
    end
  endtask

  initial begin
    int         dip_a[3];
    logic [7:0] dip_d[3];
    int         pos;

    // Reset state
    repeat (3) tick();
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_sw_we", 32'(sw_we), 32'd0);
    chk("rst_dl_done", 32'(dl_done), 32'd0);
    chk("rst_dl_error", 32'(dl_error), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_dl_sum", 32'(dl_sum), 32'd0);
    reset = 1'b0;
    tick();

    // Full sequential load, random data trimmed to the expected sum
    fill_full(1'b0, 1'b0);
    run_download("full_seq");

    // DIP bytes in RUN; addr 9 must be dropped
    dip_a[0] = 0; dip_d[0] = 8'h5A;
    dip_a[1] = 1; dip_d[1] = 8'hC3;
    dip_a[2] = 9; dip_d[2] = 8'h77;
    ioctl_index    = 8'd254;
    ioctl_download = 1'b1;
    tick();
    chk("dip_start_core_reset", 32'(core_reset), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = AW'(dip_a[i]); ioctl_dout = dip_d[i];
      tick();
      chk("sw_we", 32'(sw_we), (dip_a[i] < 8) ? 32'd1 : 32'd0);
      chk("sw_idx", 32'(sw_idx), 32'(dip_a[(dip_a[i] < 8) ? i : 1]));
      chk("sw_data", 32'(sw_data), 32'(dip_d[(dip_a[i] < 8) ? i : 1]));
      chk("dip_rom_we", 32'(rom_we), 32'd0);
      chk("dip_core_reset", 32'(core_reset), 32'd0);
      ioctl_wr = 1'b0;
      tick();
      chk("sw_we_pulse", 32'(sw_we), 32'd0);
    end
    ioctl_download = 1'b0;
    repeat (3) tick();
    chk("dip_end_core_reset", 32'(core_reset), 32'd0);
    chk("dip_end_dl_done", 32'(dl_done), 32'd1);
    $display("[TB] dip download: 2 accepted, 1 dropped");

    // Short download
    q_addr.delete(); q_data.delete();
    for (int i = 0; i < 100; i++) begin
      q_addr.push_back(i);
      q_data.push_back(8'($urandom));
    end
    run_download("short_100");

    // Full load with an extra out-of-range byte at 130
    fill_full(1'b0, 1'b0);
    pos = int'($urandom_range(TOTAL - 1, 1));
    q_addr.insert(pos, 130);
    q_data.insert(pos, 8'hEE);
    run_download("oob_130");

    // Shuffled full load, then restart from RUN and reset mid-download
    fill_full(1'b1, 1'b0);
    run_download("full_shuffled");
    ioctl_index    = 8'd0;
    ioctl_download = 1'b1;
    tick();
    chk("restart_core_reset", 32'(core_reset), 32'd1);
    chk("restart_byte_count", 32'(byte_count), 32'd0);
    chk("restart_dl_done", 32'(dl_done), 32'd0);
    for (int i = 0; i < 50; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = AW'(i); ioctl_dout = 8'($urandom);
      tick();
      ioctl_wr = 1'b0;
      tick();
    end
    chk("partial_byte_count", 32'(byte_count), 32'd50);
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_byte_count", 32'(byte_count), 32'd0);
    chk("async_sw_idx", 32'(sw_idx), 32'd0);
    chk("async_sw_data", 32'(sw_data), 32'd0);
    chk("async_rom_addr", 32'(rom_addr), 32'd0);
    chk("async_rom_data", 32'(rom_data), 32'd0);
    chk("async_dl_done", 32'(dl_done), 32'd0);
    chk("async_dl_error", 32'(dl_error), 32'd0);
    #2;
    reset = 1'b0;
    ioctl_download = 1'b0;
    repeat (HOLD_CYC + 4) tick();
    chk("after_reset_core_reset", 32'(core_reset), 32'd1);
    chk("after_reset_dl_done", 32'(dl_done), 32'd0);
    $display("[TB] restart in RUN, reset after 50 bytes");

    // All-0x01 image: sum 0x80
    fill_full(1'b0, 1'b1);
    run_download("all_ones");
`ifdef DL_CHECKSUM_EN
    chk("sum80_dl_sum", 32'(d2_dl_sum), 32'h80);
    chk("sum80_dl_done", 32'(d2_dl_done), 32'd1);
    chk("sum80_core_reset", 32'(d2_core_reset), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dl_rom_sequencer.md
Name: dl_rom_sequencer

Overview:
Controls the HPS ioctl download stream for the arcade core. It decodes each download byte into one of four ROM regions, or into the DIP switch bank. It also sequences the core's reset: the game is held in reset during a ROM download, and for a fixed settle period after one. The game is only released once a complete, in-range ROM image has loaded.

Parameters:
ADDR_W, 25, width of ioctl_addr / rom_addr
R0_SIZE, 16384, bytes in region 0 (base 0)
R1_SIZE, 8192, bytes in region 1 (base R0_SIZE)
R2_SIZE, 8192, bytes in region 2 (base R0_SIZE+R1_SIZE)
R3_SIZE, 8192, bytes in region 3 (base sum of R0..R2)
POST_HOLD, 1024, clk_sys cycles core_reset stays high after a good download
EXPECT_SUM, 8'h00, expected 8-bit ROM checksum (DL_CHECKSUM_EN only)

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  download active
ioctl_wr  in  1  byte write strobe
ioctl_addr  in  ADDR_W  byte address
ioctl_dout  in  8  byte data
ioctl_index  in  8  0 = ROM, 254 = DIP, other values ignored
rom_we  out  4  one-hot region write enable
rom_addr  out  ADDR_W  offset within the selected region
rom_data  out  8  write data
sw_we  out  1  DIP bank write
sw_idx  out  3  DIP byte index
sw_data  out  8  DIP data
core_reset  out  1  reset for the game core
dl_done  out  1  sticky: last ROM download was complete and valid
dl_error  out  1  sticky: out-of-range or short download
byte_count  out  ADDR_W  in-range ROM bytes accepted in the current/last download
dl_sum  out  8  running checksum (DL_CHECKSUM_EN only)

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is asynchronous and active-high. Reset values: state=IDLE, core_reset=1, all write strobes 0, rom_addr/rom_data/sw_* = 0, dl_done=0, dl_error=0, byte_count=0, dl_sum=0.
- TOTAL = R0_SIZE+R1_SIZE+R2_SIZE+R3_SIZE.
- ROM write (ioctl_wr & ioctl_index==0 & ioctl_download):
  - Region k is selected when base_k <= addr < base_k+size_k.
  - rom_we[k], rom_addr = addr-base_k and rom_data are registered, so they appear exactly 1 cycle after the strobe. The strobe is 1 cycle wide.
  - byte_count increments on each such write.
  - addr >= TOTAL: no rom_we, byte_count unchanged, dl_error set.
- DIP write (ioctl_wr & ioctl_index==254 & addr[ADDR_W-1:3]==0):
  - sw_we, sw_idx=addr[2:0] and sw_data are registered with 1-cycle latency, in any state.
  - A DIP write never affects core_reset or the FSM.
  - DIP writes with addr >= 8 are dropped silently.
- FSM:
  - IDLE: core_reset=1. On a rising ioctl_download with index 0 -> LOAD.
  - LOAD: on entry clear byte_count, dl_error, dl_done and dl_sum; core_reset=1. When ioctl_download falls:
    - byte_count==TOTAL and !dl_error -> HOLD, loading the counter with POST_HOLD-1.
    - otherwise set dl_error -> IDLE.
  - HOLD: core_reset=1; the counter decrements each cycle. At 0 -> RUN and set dl_done.
  - RUN: core_reset=0. A rising ioctl_download with index 0 -> LOAD, and core_reset rises on the next cycle.
- Edge cases:
  - Rising ioctl_download with index≠0 is ignored in every state.
  - A ROM download start seen during HOLD aborts the hold -> LOAD.
  - ioctl_wr on the same cycle as the rising ioctl_download: the byte is accepted and counted in the new download.
  - Rewriting the same address counts again. A duplicate write can therefore reach TOTAL falsely; this is accepted, and the loader never rewrites addresses.
  - reset asserted mid-LOAD -> IDLE immediately; the partial image is never released.

Optional Feature:
DL_CHECKSUM_EN.
- Defined: dl_sum accumulates the mod-256 sum of every accepted in-range ROM byte. At the end of LOAD, a mismatch with EXPECT_SUM is treated as an error (dl_error set, -> IDLE).
- Undefined: dl_sum is tied to 0, no checksum logic is built, and EXPECT_SUM is ignored.

Test Plan:
(Bench parameters: R sizes 16/16/32/64, TOTAL=128, POST_HOLD=8.)
- Full ROM download, 128 bytes at addr 0..127 -> rom_we one-hot 0001/0010/0100/1000 at addr 0/16/32/64, with rom_addr 0 at each boundary; dl_done=1; core_reset falls exactly 8 cycles after ioctl_download falls.
- Short download of 100 bytes -> dl_error=1, state IDLE, core_reset stays 1, dl_done=0.
- Write to addr 130 within an otherwise full load -> no rom_we for that byte, dl_error=1, core_reset stays 1.
- In RUN, DIP download of 2 bytes (0x5A at addr 0, 0xC3 at addr 1) -> sw_we pulses with sw_idx 0/1 and the same data 1 cycle later; core_reset stays 0 throughout.
- In RUN, new index-0 download -> core_reset=1 within 1 cycle and byte_count resets to 0. Assert reset at byte 50 -> outputs return to reset values asynchronously.
- With DL_CHECKSUM_EN and EXPECT_SUM=8'h40, full load of 128 bytes all 0x01 -> dl_sum=0x80, mismatch, dl_error=1. Rerun with EXPECT_SUM=8'h80 -> dl_done=1.
